// File: rtl/pc_fetch_unit.sv
// Fetch stage: owns the PC, issues word fetches to ins_mem and buffers returned instructions for decode.
// Optional build macro FETCH_MISALIGN_TRAP_EN adds a TRAP state and the fetch_misalign output.
module pc_fetch_unit #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            halt,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic            fetch_misalign
`endif
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0]   DEPTH_C  = (CW+1)'(FIFO_DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);

    localparam logic [1:0] RUN    = 2'd0;
    localparam logic [1:0] HALTED = 2'd1;
    localparam logic [1:0] FLUSH  = 2'd2;
`ifdef FETCH_MISALIGN_TRAP_EN
    localparam logic [1:0] TRAP   = 2'd3;
`endif

    logic [1:0]      state;
    logic [1:0]      next_state;
    logic [XLEN-1:0] pc;
    logic            epoch;
    logic            vld_p1;
    logic            epoch_p1;
    logic [XLEN-1:0] pc_p1;
    logic [XLEN-1:0] mem_data [FIFO_DEPTH];
    logic [XLEN-1:0] mem_pc   [FIFO_DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic            pop;
    logic            push;
    logic [CW:0]     credit;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Credit counts buffered + in-flight entries, minus the one decode takes this cycle
    always_comb begin
        inst_valid = (count != '0);
        pop        = inst_valid & inst_ready;
        credit     = {1'b0, count} + (CW+1)'(vld_p1) - (CW+1)'(pop);
        imem_req   = !rst && (state == RUN) && !halt && !redirect_valid && (credit < DEPTH_C);
        imem_addr  = {pc[XLEN-1:2], 2'b00};
        push       = vld_p1 && (epoch_p1 == epoch) && !redirect_valid;
        inst_data  = inst_valid ? mem_data[rd_ptr] : '0;
        inst_pc    = inst_valid ? mem_pc[rd_ptr]   : '0;
    end

    always_comb begin
        next_state = state;
        case (state)
            RUN:    if (halt) next_state = HALTED;
            HALTED: if (!halt) next_state = RUN;
            FLUSH: begin
                next_state = halt ? HALTED : RUN;
`ifdef FETCH_MISALIGN_TRAP_EN
                if (pc[1:0] != 2'b00) next_state = TRAP;
`endif
            end
            default: next_state = state;
        endcase
        if (redirect_valid) next_state = FLUSH;
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    assign fetch_misalign = (state == TRAP);
`endif

    // Stage p0 -> p1: issue bookkeeping and FIFO control
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            pc       <= RESET_PC;
            epoch    <= 1'b0;
            vld_p1   <= 1'b0;
            epoch_p1 <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            state    <= next_state;
            vld_p1   <= imem_req;
            epoch_p1 <= epoch;
            if (redirect_valid) begin
                pc     <= redirect_pc;
                epoch  <= ~epoch;
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (imem_req) pc <= pc + XLEN'(4);
                if (push) wr_ptr <= ptr_inc(wr_ptr);
                if (pop)  rd_ptr <= ptr_inc(rd_ptr);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    // Stage p1: response capture into the instruction buffer
    always_ff @(posedge clk) begin
        pc_p1 <= pc;
        if (push) begin
            mem_data[wr_ptr] <= imem_rdata;
            mem_pc[wr_ptr]   <= pc_p1;
        end
    end
endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: in-order stream model plus directed literal checks.
// Honours FETCH_MISALIGN_TRAP_EN for the misaligned-redirect scenario.
module tb_pc_fetch_unit;
    logic        clk = 1'b0;
    logic        rst, halt, redirect_valid, inst_ready;
    logic [31:0] redirect_pc, imem_rdata, mem_next;
    logic        imem_req, inst_valid;
    logic [31:0] imem_addr, inst_data, inst_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        fetch_misalign;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    pc_fetch_unit dut (
        .clk(clk), .rst(rst), .halt(halt),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_data(inst_data), .inst_pc(inst_pc)
`ifdef FETCH_MISALIGN_TRAP_EN
        , .fetch_misalign(fetch_misalign)
`endif
    );

    always #5 clk = ~clk;

    // Instruction memory: word at byte address A holds A + 0x1000, returned one cycle later
    initial imem_rdata = 32'hDEAD_BEEF;
    always @(negedge clk) mem_next = imem_req ? (imem_addr + 32'h1000) : 32'hDEAD_BEEF;
    always @(posedge clk) imem_rdata <= mem_next;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Stream model: delivered PCs and request addresses each form an unbroken +4 sequence
    // restarted by every redirect; buffered + in-flight never exceeds the buffer depth.
    logic [31:0] exp_pc, exp_req;
    int          outstanding;
    logic        held, trap_exp;

    always @(negedge clk) begin
        if (rst) begin
            exp_pc      = 32'h0;
            exp_req     = 32'h0;
            outstanding = 0;
            held        = 1'b0;
            trap_exp    = 1'b0;
            chk("rst_req", {31'b0, imem_req}, 32'd0);
        end else begin
            if (held) chk("head_held_valid", {31'b0, inst_valid}, 32'd1);
            if (inst_valid) begin
                chk("head_pc", inst_pc, exp_pc);
                chk("head_data", inst_data, (exp_pc & ~32'h3) + 32'h1000);
            end
            if (inst_valid && inst_ready) exp_pc = exp_pc + 32'd4;
            if (imem_req) begin
                chk("req_addr", imem_addr, exp_req & ~32'h3);
                chk("req_allowed", {31'b0, halt | redirect_valid | trap_exp}, 32'd0);
                exp_req = exp_req + 32'd4;
            end
            outstanding = outstanding + (imem_req ? 1 : 0) - ((inst_valid && inst_ready) ? 1 : 0);
            if (outstanding > 2) begin
                n_cmp++;
                n_fail++;
                $display("FAIL credit_overflow: got %0d outstanding, limit 2", outstanding);
            end
            held = inst_valid && !inst_ready && !redirect_valid;
            if (redirect_valid) begin
                exp_pc      = redirect_pc;
                exp_req     = redirect_pc;
                outstanding = 0;
`ifdef FETCH_MISALIGN_TRAP_EN
                trap_exp    = (redirect_pc[1:0] != 2'b00);
`endif
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; halt = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; inst_ready = 1'b0;
        cyc(); cyc(); mid();
        chk("reset_req",   {31'b0, imem_req},   32'd0);
        chk("reset_valid", {31'b0, inst_valid}, 32'd0);
        chk("reset_data",  inst_data, 32'h0);
        chk("reset_pc",    inst_pc,   32'h0);

        // Streaming with decode always ready
        cyc(); rst = 1'b0; inst_ready = 1'b1;
        mid(); chk("s_c0_req", {31'b0, imem_req}, 32'd1); chk("s_c0_addr", imem_addr, 32'h0);
        cyc(); mid(); chk("s_c1_addr", imem_addr, 32'h4); chk("s_c1_valid", {31'b0, inst_valid}, 32'd0);
        cyc(); mid(); chk("s_c2_pc", inst_pc, 32'h0); chk("s_c2_data", inst_data, 32'h1000);
        chk("s_c2_addr", imem_addr, 32'h8);
        cyc(); mid(); chk("s_c3_pc", inst_pc, 32'h4); chk("s_c3_data", inst_data, 32'h1004);
        cyc(); mid(); chk("s_c4_pc", inst_pc, 32'h8); chk("s_c4_data", inst_data, 32'h1008);

        // Decode stalls for 5 cycles after the first valid
        inst_ready = 1'b0;
        do_reset();
        cyc(); cyc(); mid(); chk("st_c2_pc", inst_pc, 32'h0);
        for (int i = 0; i < 4; i++) begin
            cyc(); mid();
            chk("st_full_req", {31'b0, imem_req}, 32'd0);
            chk("st_full_head", inst_pc, 32'h0);
        end
        cyc(); inst_ready = 1'b1;
        mid(); chk("st_c7_pc", inst_pc, 32'h0); chk("st_c7_addr", imem_addr, 32'h8);
        cyc(); mid(); chk("st_c8_pc", inst_pc, 32'h4);
        cyc(); mid(); chk("st_c9_pc", inst_pc, 32'h8);

        // Redirect with one entry buffered and a response in flight
        inst_ready = 1'b0;
        do_reset();
        cyc(); cyc(); redirect_valid = 1'b1; redirect_pc = 32'h100;
        mid(); chk("rd_t_req", {31'b0, imem_req}, 32'd0);
        cyc(); redirect_valid = 1'b0;
        mid(); chk("rd_t1_valid", {31'b0, inst_valid}, 32'd0); chk("rd_t1_req", {31'b0, imem_req}, 32'd0);
        cyc(); mid(); chk("rd_t2_addr", imem_addr, 32'h100); chk("rd_t2_req", {31'b0, imem_req}, 32'd1);
        cyc(); mid(); chk("rd_t3_valid", {31'b0, inst_valid}, 32'd0);
        cyc(); inst_ready = 1'b1;
        mid(); chk("rd_t4_pc", inst_pc, 32'h100); chk("rd_t4_data", inst_data, 32'h1100);

        // Redirect in the same cycle as a pop
        cyc(); redirect_valid = 1'b1; redirect_pc = 32'h300;
        mid(); chk("rp_pop_pc", inst_pc, 32'h104);
        cyc(); redirect_valid = 1'b0;
        mid(); chk("rp_t1_valid", {31'b0, inst_valid}, 32'd0);
        cyc(); mid(); chk("rp_t2_addr", imem_addr, 32'h300);
        cyc(); cyc(); mid(); chk("rp_t4_pc", inst_pc, 32'h300);

        // Halt for 4 cycles
        do_reset();
        cyc(); cyc(); cyc(); halt = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mid(); chk("h_no_req", {31'b0, imem_req}, 32'd0);
            cyc();
        end
        halt = 1'b0;
        cyc(); mid(); chk("h_resume_req", {31'b0, imem_req}, 32'd1); chk("h_resume_addr", imem_addr, 32'hC);

        // Misaligned redirect
        cyc(); redirect_valid = 1'b1; redirect_pc = 32'h102;
        cyc(); redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        mid(); chk("m_flush_flag", {31'b0, fetch_misalign}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            cyc(); mid();
            chk("m_trap_flag", {31'b0, fetch_misalign}, 32'd1);
            chk("m_trap_req", {31'b0, imem_req}, 32'd0);
        end
`else
        cyc(); mid(); chk("m_addr_masked", imem_addr, 32'h100);
        cyc(); cyc(); mid(); chk("m_pc", inst_pc, 32'h102); chk("m_data", inst_data, 32'h1100);
`endif
        cyc(); redirect_valid = 1'b1; redirect_pc = 32'h200;
        cyc(); redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        mid(); chk("m_clear_flag", {31'b0, fetch_misalign}, 32'd0);
`endif
        cyc(); mid(); chk("m_new_addr", imem_addr, 32'h200); chk("m_new_req", {31'b0, imem_req}, 32'd1);
        cyc(); cyc(); mid(); chk("m_new_pc", inst_pc, 32'h200);
        cyc(); cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
